caravel_mprj_counter: RTL and testbench



---
 rtl/caravel_mprj_counter_pkg.sv | 13 +
 rtl/caravel_mprj_counter_if.sv | 27 ++
 rtl/caravel_mprj_counter_wb_slave_if.sv | 82 ++++++++
 rtl/caravel_mprj_counter.sv | 113 +++++++++++
 tb/tb_caravel_mprj_counter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/caravel_mprj_counter_pkg.sv
// caravel_mprj_counter_pkg
// Shared constants for the Caravel user-project counter: Wishbone register
// offsets, the CTRL enable bit position and the default Wishbone base address.
// No ports (package).
package caravel_mprj_counter_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADR = 32'h3000_0000;

  localparam logic [3:0]  COUNT_OFS   = 4'h0;
  localparam logic [3:0]  CTRL_OFS    = 4'h4;
  localparam int          CTRL_EN_BIT = 0;

endpackage

// File: rtl/caravel_mprj_counter_if.sv
// caravel_mprj_counter_if
// Wishbone classic slave bundle between the management SoC and the counter.
// Signals: wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i[3:0], wbs_adr_i[31:0],
// wbs_dat_i[31:0] (master to slave); wbs_ack_o, wbs_dat_o[31:0] (slave to master).
// Modports: master (SoC / testbench side), slave (counter side).
interface caravel_mprj_counter_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/caravel_mprj_counter_wb_slave_if.sv
// caravel_mprj_counter_wb_slave_if
// Wishbone slave front end: address decode, single-shot registered ack,
// registered read mux and byte-lane merge of write data with the live register.
// Ports:
//   clock, resetb             clock and asynchronous active-low reset
//   wbs                       Wishbone slave modport
//   count, en                 current COUNT / CTRL.en values (readback, merge)
//   wr_count_s, wr_ctrl_s     one-cycle write strobes, valid on the ack-raising edge
//   wr_count_data_s           byte-merged COUNT write value
//   wr_en_data_s              byte-merged CTRL.en write value
module caravel_mprj_counter_wb_slave_if
  import caravel_mprj_counter_pkg::*;
#(
  parameter int          COUNT_W  = 32,
  parameter logic [31:0] BASE_ADR = DEFAULT_BASE_ADR
) (
  input  logic               clock,
  input  logic               resetb,
  caravel_mprj_counter_if.slave wbs,
  input  logic [COUNT_W-1:0] count,
  input  logic               en,
  output logic               wr_count_s,
  output logic               wr_ctrl_s,
  output logic [COUNT_W-1:0] wr_count_data_s,
  output logic               wr_en_data_s
);

  logic        hit_s;
  logic        take_s;
  logic [3:0]  ofs_s;
  logic [31:0] count_ext_s;
  logic [31:0] rd_data_s;
  logic [31:0] merged_s;
  logic        ack_r;
  logic [31:0] dat_r;

  // Decode, read mux and byte-lane merge.
  always_comb begin
    hit_s       = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                  (wbs.wbs_adr_i[31:4] == BASE_ADR[31:4]);
    // The cycle right after an ack is never accepted, so a held strobe
    // cannot be acked (or written) twice back to back.
    take_s      = hit_s & ~ack_r;
    ofs_s       = wbs.wbs_adr_i[3:0];
    count_ext_s = 32'(count);
    case (ofs_s)
      COUNT_OFS: rd_data_s = count_ext_s;
      CTRL_OFS:  rd_data_s = {31'h0000_0000, en};
      default:   rd_data_s = 32'h0000_0000;
    endcase
    for (int k = 0; k < 4; k++) begin
      if (wbs.wbs_sel_i[k]) begin
        merged_s[8*k +: 8] = wbs.wbs_dat_i[8*k +: 8];
      end else begin
        merged_s[8*k +: 8] = count_ext_s[8*k +: 8];
      end
    end
    wr_count_s      = take_s & wbs.wbs_we_i & (ofs_s == COUNT_OFS);
    wr_ctrl_s       = take_s & wbs.wbs_we_i & (ofs_s == CTRL_OFS);
    wr_count_data_s = merged_s[COUNT_W-1:0];
    if (wbs.wbs_sel_i[0]) begin
      wr_en_data_s = wbs.wbs_dat_i[CTRL_EN_BIT];
    end else begin
      wr_en_data_s = en;
    end
  end

  // Registered ack and read data; data is zero whenever ack is low.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      ack_r <= 1'b0;
      dat_r <= 32'h0000_0000;
    end else begin
      ack_r <= take_s;
      dat_r <= (take_s & ~wbs.wbs_we_i) ? rd_data_s : 32'h0000_0000;
    end
  end

  assign wbs.wbs_ack_o = ack_r;
  assign wbs.wbs_dat_o = dat_r;

endmodule

// File: rtl/caravel_mprj_counter.sv
// caravel_mprj_counter
// Free-running software-visible counter for the Caravel user project area.
// Readable/writable over Wishbone, per-bit overridable from the LA probes,
// low 16 bits shown on user pads io[23:8].
// Ports:
//   clock, resetb        clock and asynchronous active-low reset
//   wbs                  Wishbone slave modport
//   la_data_in, la_oenb  LA override value / per-bit active-low override enable
//   io_in                pad inputs (ignored)
//   io_out, io_oeb       pad outputs / active-low output enables
//   irq[2:0]             interrupts; irq[0] = wrap pulse when
//                        CARAVEL_MPRJ_COUNTER_IRQ_EN is defined, else 0
module caravel_mprj_counter
  import caravel_mprj_counter_pkg::*;
#(
  parameter int          COUNT_W  = 32,
  parameter int          IO_BITS  = 38,
  parameter logic [31:0] BASE_ADR = DEFAULT_BASE_ADR
) (
  input  logic               clock,
  input  logic               resetb,
  caravel_mprj_counter_if.slave wbs,
  input  logic [COUNT_W-1:0] la_data_in,
  input  logic [COUNT_W-1:0] la_oenb,
  input  logic [IO_BITS-1:0] io_in,
  output logic [IO_BITS-1:0] io_out,
  output logic [IO_BITS-1:0] io_oeb,
  output logic [2:0]         irq
);

  logic [COUNT_W-1:0] count_r;
  logic [COUNT_W-1:0] base_s;
  logic [COUNT_W-1:0] count_nxt_s;
  logic               en_r;
  logic               oe_r;
  logic               irq0_r;
  logic               wr_count_s;
  logic               wr_ctrl_s;
  logic [COUNT_W-1:0] wr_count_data_s;
  logic               wr_en_data_s;
  logic               unused_io_s;

  assign unused_io_s = ^io_in;

  caravel_mprj_counter_wb_slave_if #(
    .COUNT_W  (COUNT_W),
    .BASE_ADR (BASE_ADR)
  ) u_wb (
    .clock           (clock),
    .resetb          (resetb),
    .wbs             (wbs),
    .count           (count_r),
    .en              (en_r),
    .wr_count_s      (wr_count_s),
    .wr_ctrl_s       (wr_ctrl_s),
    .wr_count_data_s (wr_count_data_s),
    .wr_en_data_s    (wr_en_data_s)
  );

  // Next count: a bus write beats increment/hold, and the LA override beats both per bit.
  always_comb begin
    base_s = count_r;
    if (wr_count_s) begin
      base_s = wr_count_data_s;
    end else if (en_r) begin
      base_s = count_r + COUNT_W'(1);
    end else begin
      base_s = count_r;
    end
    count_nxt_s = (la_data_in & ~la_oenb) | (base_s & la_oenb);
  end

`ifdef CARAVEL_MPRJ_COUNTER_IRQ_EN
  logic wrap_s;

  // Only an increment-driven all-ones -> 0 transition counts as a wrap.
  always_comb begin
    wrap_s = ~wr_count_s & en_r & (&count_r) & (&la_oenb);
  end
`endif

  // Counter, CTRL.en, pad-enable and interrupt state.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      count_r <= {COUNT_W{1'b0}};
      en_r    <= 1'b1;
      oe_r    <= 1'b0;
      irq0_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      oe_r    <= 1'b1;
      if (wr_ctrl_s) begin
        en_r <= wr_en_data_s;
      end
`ifdef CARAVEL_MPRJ_COUNTER_IRQ_EN
      irq0_r  <= wrap_s;
`else
      irq0_r  <= 1'b0;
`endif
    end
  end

  // Pad mapping: count[15:0] on io[23:8], everything else an undriven input.
  always_comb begin
    io_out        = {IO_BITS{1'b0}};
    io_out[23:8]  = count_r[15:0];
    io_oeb        = {IO_BITS{1'b1}};
    io_oeb[23:8]  = {16{~oe_r}};
  end

  assign irq = {2'b00, irq0_r};

endmodule

// File: tb/tb_caravel_mprj_counter.sv
// tb_caravel_mprj_counter
// Directed bench for caravel_mprj_counter: a table of Wishbone accesses with
// hand-computed results run while the counter is frozen, plus hand-written
// sequences for reset, free-running count, LA override, wrap/irq, held strobe
// and reset during an access. Honors CARAVEL_MPRJ_COUNTER_IRQ_EN.
module tb_caravel_mprj_counter;

  localparam logic [31:0] COUNT_A  = 32'h3000_0000;
  localparam logic [31:0] CTRL_A   = 32'h3000_0004;
  localparam logic [31:0] R8_A     = 32'h3000_0008;
  localparam logic [31:0] RC_A     = 32'h3000_000C;
  localparam logic [31:0] MISS_A   = 32'h3000_0100;
  localparam logic [37:0] PAD_MASK = 38'h00_00FF_FF00;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        ack;
    logic [31:0] rd;
  } vec_t;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic [31:0] la_data_in = 32'h0;
  logic [31:0] la_oenb = 32'hFFFF_FFFF;
  logic [37:0] io_in = 38'h0;
  logic [37:0] io_out;
  logic [37:0] io_oeb;
  logic [2:0]  irq;

  int n_vec = 0;
  int n_bad = 0;

  caravel_mprj_counter_if wbs ();

  caravel_mprj_counter dut (
    .clock      (clock),
    .resetb     (resetb),
    .wbs        (wbs.slave),
    .la_data_in (la_data_in),
    .la_oenb    (la_oenb),
    .io_in      (io_in),
    .io_out     (io_out),
    .io_oeb     (io_oeb),
    .irq        (irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_ge(input string nm, input logic [31:0] act, input logic [31:0] lo);
    n_vec++;
    if (act < lo) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required >= 0x%0h", nm, act, lo);
    end
  endtask

  task automatic bus_idle();
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
    wbs.wbs_sel_i = 4'h0;
    wbs.wbs_adr_i = 32'h0;
    wbs.wbs_dat_i = 32'h0;
  endtask

  task automatic bus_drive(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_we_i  = we;
    wbs.wbs_sel_i = sel;
    wbs.wbs_adr_i = adr;
    wbs.wbs_dat_i = dat;
  endtask

  // One access: drive on a falling edge, wait up to 6 cycles for ack, release,
  // then sample ack one more cycle later (must already be low again).
  task automatic wb_acc(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic got_ack,
                        output logic [31:0] rdata, output logic ack_after);
    @(negedge clock);
    bus_drive(we, adr, dat, sel);
    got_ack   = 1'b0;
    rdata     = 32'h0;
    ack_after = 1'b0;
    for (int i = 0; i < 6 && !got_ack; i++) begin
      @(posedge clock);
      #1;
      if (wbs.wbs_ack_o) begin
        got_ack = 1'b1;
        rdata   = wbs.wbs_dat_o;
      end
    end
    bus_idle();
    @(posedge clock);
    #1;
    ack_after = wbs.wbs_ack_o;
  endtask

  vec_t        tbl [20];
  logic        a, aa;
  logic [31:0] d, r1, r2;
  int          acks, irq_hits, irq_exp;

  initial begin
    // Frozen-counter register tests; the first entry stops the counter.
    tbl[0]  = '{1'b1, CTRL_A,  32'h0000_0000, 4'hF, 1'b1, 32'h0};
    tbl[1]  = '{1'b1, COUNT_A, 32'h1111_2222, 4'hF, 1'b1, 32'h0};
    tbl[2]  = '{1'b0, COUNT_A, 32'h0,         4'hF, 1'b1, 32'h1111_2222};
    tbl[3]  = '{1'b1, COUNT_A, 32'h1234_5678, 4'b0010, 1'b1, 32'h0};
    tbl[4]  = '{1'b0, COUNT_A, 32'h0,         4'hF, 1'b1, 32'h1111_5622};
    tbl[5]  = '{1'b0, COUNT_A, 32'h0,         4'hF, 1'b1, 32'h1111_5622};
    tbl[6]  = '{1'b0, CTRL_A,  32'h0,         4'hF, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, R8_A,    32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    tbl[8]  = '{1'b0, R8_A,    32'h0,         4'hF, 1'b1, 32'h0};
    tbl[9]  = '{1'b1, RC_A,    32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    tbl[10] = '{1'b0, RC_A,    32'h0,         4'hF, 1'b1, 32'h0};
    tbl[11] = '{1'b0, COUNT_A, 32'h0,         4'hF, 1'b1, 32'h1111_5622};
    tbl[12] = '{1'b1, MISS_A,  32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
    tbl[13] = '{1'b0, MISS_A,  32'h0,         4'hF, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 32'h3100_0000, 32'h0,   4'hF, 1'b0, 32'h0};
    tbl[15] = '{1'b0, COUNT_A, 32'h0,         4'hF, 1'b1, 32'h1111_5622};
    tbl[16] = '{1'b1, COUNT_A, 32'hAABB_CCDD, 4'b1001, 1'b1, 32'h0};
    tbl[17] = '{1'b0, COUNT_A, 32'h0,         4'hF, 1'b1, 32'hAA11_56DD};
    tbl[18] = '{1'b1, CTRL_A,  32'h0000_0001, 4'h0, 1'b1, 32'h0};
    tbl[19] = '{1'b0, CTRL_A,  32'h0,         4'hF, 1'b1, 32'h0};

    bus_idle();

    // Reset values.
    repeat (3) @(negedge clock);
    chk("rst ack", {63'h0, wbs.wbs_ack_o}, 64'h0);
    chk("rst dat", {32'h0, wbs.wbs_dat_o}, 64'h0);
    chk("rst irq", {61'h0, irq}, 64'h0);
    chk("rst io_out", {26'h0, io_out}, 64'h0);
    chk("rst io_oeb", {26'h0, io_oeb}, {26'h0, 38'h3F_FFFF_FFFF});

    // Free-running after reset with no traffic.
    resetb = 1'b1;
    repeat (10) @(posedge clock);
    wb_acc(1'b0, COUNT_A, 32'h0, 4'hF, a, d, aa);
    chk("run ack", {63'h0, a}, 64'h1);
    chk_ge("run count>=10", d, 32'd10);
    // Two more increments happen between the sampled value and the pad check.
    chk("run pads", {48'h0, io_out[23:8]}, {48'h0, d[15:0] + 16'd2});
    chk("run io_oeb", {26'h0, io_oeb}, {26'h0, ~PAD_MASK});

    // Table of frozen-counter accesses.
    for (int i = 0; i < 20; i++) begin
      wb_acc(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, a, d, aa);
      chk($sformatf("v%0d ack", i), {63'h0, a}, {63'h0, tbl[i].ack});
      if (tbl[i].ack) begin
        chk($sformatf("v%0d ack width", i), {63'h0, aa}, 64'h0);
        if (!tbl[i].we) chk($sformatf("v%0d data", i), {32'h0, d}, {32'h0, tbl[i].rd});
      end
    end
    chk("frozen pads", {48'h0, io_out[23:8]}, 64'h56DD);
    chk("frozen other pads", {26'h0, io_out & ~PAD_MASK}, 64'h0);

    // Strobe held after ack: next cycle must not ack, data returns to 0.
    @(negedge clock);
    bus_drive(1'b0, COUNT_A, 32'h0, 4'hF);
    a = 1'b0;
    for (int i = 0; i < 6 && !a; i++) begin
      @(posedge clock);
      #1;
      if (wbs.wbs_ack_o) begin
        a = 1'b1;
        d = wbs.wbs_dat_o;
      end
    end
    chk("held ack", {63'h0, a}, 64'h1);
    chk("held data", {32'h0, d}, 64'hAA11_56DD);
    @(posedge clock);
    #1;
    chk("held gap ack", {63'h0, wbs.wbs_ack_o}, 64'h0);
    chk("held gap dat", {32'h0, wbs.wbs_dat_o}, 64'h0);
    bus_idle();
    @(posedge clock);

    // LA override on the low byte; it also beats a simultaneous bus write.
    @(negedge clock);
    la_oenb    = 32'hFFFF_FF00;
    la_data_in = 32'h0000_00A5;
    wb_acc(1'b1, COUNT_A, 32'h0102_0304, 4'hF, a, d, aa);
    wb_acc(1'b0, COUNT_A, 32'h0, 4'hF, a, d, aa);
    chk("la vs write", {32'h0, d}, 64'h0102_03A5);
    wb_acc(1'b1, CTRL_A, 32'h0000_0001, 4'hF, a, d, aa);
    // Low byte pinned at A5 means count+1 never carries into bit 8,
    // so the upper bits hold.
    for (int c = 0; c < 8; c++) begin
      @(posedge clock);
      #1;
      chk($sformatf("la low c%0d", c), {56'h0, io_out[15:8]}, 64'hA5);
      chk($sformatf("la high c%0d", c), {56'h0, io_out[23:16]}, 64'h03);
    end
    wb_acc(1'b0, COUNT_A, 32'h0, 4'hF, a, d, aa);
    chk("la count", {32'h0, d}, 64'h0102_03A5);
    @(negedge clock);
    la_oenb    = 32'hFFFF_FFFF;
    la_data_in = 32'h0;

    // Wrap through increment: FFFE -> FFFF -> 0 on successive edges.
`ifdef CARAVEL_MPRJ_COUNTER_IRQ_EN
    irq_exp = 1;
`else
    irq_exp = 0;
`endif
    acks = 0;
    irq_hits = 0;
    @(negedge clock);
    bus_drive(1'b1, COUNT_A, 32'hFFFF_FFFE, 4'hF);
    for (int c = 0; c < 8; c++) begin
      @(posedge clock);
      #1;
      if (wbs.wbs_ack_o) acks++;
      if (irq[0]) irq_hits++;
      if (c == 0) begin
        bus_idle();
        chk("wrap c0 pads", {48'h0, io_out[23:8]}, 64'hFFFE);
      end
      if (c == 1) chk("wrap c1 pads", {48'h0, io_out[23:8]}, 64'hFFFF);
      if (c == 2) chk("wrap c2 pads", {48'h0, io_out[23:8]}, 64'h0000);
      chk($sformatf("irq hi c%0d", c), {62'h0, irq[2:1]}, 64'h0);
    end
    chk("wrap acks", acks, 64'd1);
    chk("wrap irq pulses", irq_hits, irq_exp);

    // Write then read twice 5 cycles apart while running.
    wb_acc(1'b1, COUNT_A, 32'h0000_AB40, 4'hF, a, d, aa);
    chk("ab40 wack", {63'h0, a}, 64'h1);
    chk("ab40 wack width", {63'h0, aa}, 64'h0);
    wb_acc(1'b0, COUNT_A, 32'h0, 4'hF, a, r1, aa);
    chk("ab40 r1 ack width", {63'h0, aa}, 64'h0);
    chk_ge("ab40 r1", r1, 32'h0000_AB41);
    repeat (5) @(posedge clock);
    wb_acc(1'b0, COUNT_A, 32'h0, 4'hF, a, r2, aa);
    chk_ge("ab40 r2 advanced", r2, r1 + 32'd1);

    // Reset asserted mid-access; LA pins count to 0 so it reads 0 after release.
    @(negedge clock);
    la_oenb    = 32'h0;
    la_data_in = 32'h0;
    bus_drive(1'b0, COUNT_A, 32'h0, 4'hF);
    a = 1'b0;
    for (int i = 0; i < 6 && !a; i++) begin
      @(posedge clock);
      #1;
      a = wbs.wbs_ack_o;
    end
    chk("mid ack seen", {63'h0, a}, 64'h1);
    #2;
    resetb = 1'b0;
    #1;
    chk("mid rst ack", {63'h0, wbs.wbs_ack_o}, 64'h0);
    chk("mid rst dat", {32'h0, wbs.wbs_dat_o}, 64'h0);
    bus_idle();
    repeat (2) @(negedge clock);
    resetb = 1'b1;
    wb_acc(1'b0, COUNT_A, 32'h0, 4'hF, a, d, aa);
    chk("post rst ack", {63'h0, a}, 64'h1);
    chk("post rst count", {32'h0, d}, 64'h0);
    wb_acc(1'b0, CTRL_A, 32'h0, 4'hF, a, d, aa);
    chk("post rst en", {32'h0, d}, 64'h1);
    @(negedge clock);
    la_oenb = 32'hFFFF_FFFF;
    repeat (3) @(posedge clock);
    wb_acc(1'b0, COUNT_A, 32'h0, 4'hF, a, d, aa);
    chk_ge("post rst runs", d, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
